// File: rtl/ddr2_controller_ex_lfsr_gen_chk.sv
// Multi-lane 8-bit LFSR pattern generator / read-data checker.
// Each byte lane runs x^8+x^4+x^3+x^2+1. In check mode every accepted beat is
// compared against the current pattern, and error status is accumulated.
module ddr2_controller_ex_lfsr_gen_chk #(
  parameter int LANES     = 4,
  parameter int SEED      = 32,
  parameter int ERR_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   pause,
  input  logic                   load,
  input  logic [8*LANES-1:0]     ldata,
  input  logic                   mode,
  input  logic                   chk_valid,
  input  logic [8*LANES-1:0]     chk_data,
  input  logic                   clr_err,
  output logic [8*LANES-1:0]     data,
  output logic [LANES-1:0]       err_lane,
  output logic                   err_sticky,
  output logic [ERR_CNT_W-1:0]   err_count,
  output logic [8*LANES-1:0]     first_exp,
  output logic [8*LANES-1:0]     first_act
);

  localparam int W = 8 * LANES;

  // Lane seeds are SEED+i modulo 256; an all-zero seed would lock the lane.
  function automatic logic [W-1:0] seeds();
    logic [W-1:0] s;
    logic [7:0]   b;
    s = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      b = 8'(SEED + int'(i));
      if (b == 8'h00) b = 8'h01;
      s[8*i +: 8] = b;
    end
    return s;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    logic [7:0] n;
    n[0] = q[7];
    n[1] = q[0];
    n[2] = q[1] ^ q[7];
    n[3] = q[2] ^ q[7];
    n[4] = q[3] ^ q[7];
    n[5] = q[4];
    n[6] = q[5];
    n[7] = q[6];
    return n;
  endfunction

  logic             compare;
  logic             advance;
  logic             bad;
  logic [LANES-1:0] mism;
  logic [W-1:0]     data_adv;

  // Compare qualification, per-lane mismatch and advanced pattern.
  always_comb begin
    compare  = mode && chk_valid && enable && !load;
    advance  = mode ? chk_valid : !pause;
    data_adv = '0;
    mism     = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      data_adv[8*i +: 8] = lfsr_next(data[8*i +: 8]);
      mism[i]            = data[8*i +: 8] != chk_data[8*i +: 8];
    end
    bad = compare && (mism != '0);
  end

  // Pattern register: reset, reload seeds, load, advance, else hold.
  always_ff @(posedge clk) begin
    if (reset)        data <= seeds();
    else if (!enable) data <= seeds();
    else if (load)    data <= ldata;
    else if (advance) data <= data_adv;
  end

  // Error state; a mismatch in the same cycle as clr_err takes precedence
  // and restarts the count at 1 with this beat captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_lane   <= '0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      first_exp  <= '0;
      first_act  <= '0;
    end else begin
      err_lane <= compare ? mism : '0;
      if (bad)          err_sticky <= 1'b1;
      else if (clr_err) err_sticky <= 1'b0;
      if (clr_err)
        err_count <= bad ? ERR_CNT_W'(1) : '0;
      else if (bad && (err_count != '1))
        err_count <= err_count + ERR_CNT_W'(1);
      if (bad && (!err_sticky || clr_err)) begin
        first_exp <= data;
        first_act <= chk_data;
      end else if (clr_err) begin
        first_exp <= '0;
        first_act <= '0;
      end
    end
  end

endmodule

// File: doc/ddr2_controller_ex_lfsr_gen_chk.md
DDR2_CONTROLLER_EX_LFSR_GEN_CHK -- requirements
Module: ddr2_controller_ex_lfsr_gen_chk

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning the number of independent 8-bit LFSR byte lanes (legal range 1..8).
REQ-002 SHALL have parameter SEED, default 32, meaning the lane-0 seed; lane i seed = (SEED + i) mod 256, and a computed value of 0 is replaced by 8'h01.
REQ-003 SHALL have parameter ERR_CNT_W, default 16, meaning the width of the error counter.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  low: reload all lanes with their seeds.
REQ-007 pause  in  1  high: hold the generator in generate mode.
REQ-008 load  in  1  high: load ldata into the lanes.
REQ-009 ldata  in  8*LANES  load value; lane i = bits [8i+7:8i].
REQ-010 mode  in  1  0 = generate, 1 = check.
REQ-011 chk_valid  in  1  chk_data beat presented this cycle (check mode only).
REQ-012 chk_data  in  8*LANES  received read data to compare.
REQ-013 clr_err  in  1  clear error state.
REQ-014 data  out  8*LANES  current expected/generated pattern (register outputs).
REQ-015 err_lane  out  LANES  per-lane mismatch of the previous accepted beat.
REQ-016 err_sticky  out  1  any mismatch since the last reset/clr_err.
REQ-017 err_count  out  ERR_CNT_W  count of mismatching beats, saturating.
REQ-018 first_exp, first_act  out  8*LANES each  expected and actual data of the first mismatching beat.

Function
REQ-019 Each lane SHALL advance as: n[0]=q[7], n[1]=q[0], n[2]=q[1]^q[7], n[3]=q[2]^q[7], n[4]=q[3]^q[7], n[5]=q[4], n[6]=q[5], n[7]=q[6]; polynomial x^8+x^4+x^3+x^2+1.
REQ-020 Lane update priority SHALL be: reset, then !enable (reload seeds), then load (ldata), then advance, else hold.
REQ-021 The advance condition SHALL be !pause in mode 0, and chk_valid in mode 1 (pause ignored).
REQ-022 In mode 1 with chk_valid=1 and enable=1 and load=0, chk_data SHALL be compared lane-wise against data in the same cycle, and the result SHALL be registered into err_lane (1-cycle latency).
REQ-023 err_lane SHALL be all-zero in any cycle following a cycle with no compare.
REQ-024 A beat with any lane mismatch SHALL set err_sticky and increment err_count by exactly 1, regardless of the number of failing lanes.
REQ-025 err_count SHALL saturate at 2^ERR_CNT_W-1 without wrapping.
REQ-026 first_exp/first_act SHALL capture only the first mismatching beat while err_sticky=0, and SHALL hold afterwards.
REQ-027 clr_err SHALL clear err_sticky, err_count, first_exp, first_act and err_lane; a mismatch in the same cycle SHALL win: result is sticky=1, count=1, and that beat captured.
REQ-028 !enable and load SHALL NOT affect error state; a chk_valid in those cycles SHALL NOT be compared.
REQ-029 mode changes SHALL take effect on the next cycle's advance decision, with no reload.
REQ-030 A lane reaching 8'h00 through load SHALL remain 0 (lockup permitted; the loader is responsible for avoiding it).

Reset
REQ-031 On reset SHALL set: each lane = its seed; err_lane=0; err_sticky=0; err_count=0; first_exp=0; first_act=0.
REQ-032 reset asserted mid-operation SHALL override every other input in that cycle.

Verification
REQ-033 LANES=1, SEED=32, mode 0, enable=1, pause=0 after reset -> data = 0x20, 0x40, 0x80, 0x1D on successive cycles.
REQ-034 LANES=4, SEED=255 -> lane seeds after reset = 0xFF, 0x01 (0x00 replaced), 0x01, 0x02.
REQ-035 Mode 1, 4 beats of chk_data = data with lane 2 of beat 3 flipped -> err_lane=4'b0100 for one cycle, err_count=1, err_sticky=1, first_exp/first_act = that beat; the generator advances only on the 4 valid beats.
REQ-036 ERR_CNT_W=2, 5 consecutive bad beats -> err_count = 1, 2, 3, 3, 3.
REQ-037 clr_err coincident with a bad beat -> err_count=1, err_sticky=1; clr_err alone -> all error outputs 0 on the next cycle.
REQ-038 reset, enable=0, load and advance pulsed in the same cycle -> seeds loaded, error state cleared; then enable=0 with load=1 -> seeds loaded, error state untouched.
